// File: rtl/clk_div_controller.sv
// rtl/clk_div_controller.sv - run-time controller for the counter-based clock divider
//
// Owns the divider counter and sequences it: start/stop with whole-period
// completion, half-period reconfiguration through a valid/ready handshake,
// and a one-cycle tick on every rising edge of the divided clock.
//
// Optional feature macro: CLKDIV_TICK_COUNT_EN adds the tick_cnt output.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   start      level request to begin or resume running
//   stop       level request to halt at the end of the current period
//   cfg_valid  new half-period offered on cfg_half
//   cfg_half   new half-period H (each half period lasts H+1 cycles)
//   cfg_ready  a configuration can be accepted this cycle
//   busy       high while running or stopping
//   tick       one-cycle pulse in the first cycle of clkOut high
//   clkOut     divided clock, period 2*(H+1) cycles
//   tick_cnt   (CLKDIV_TICK_COUNT_EN only) free-running count of ticks

module clk_div_controller #(
    parameter int          N            = 26,
    parameter int unsigned HALF_DEFAULT = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         cfg_valid,
    input  logic [N-1:0] cfg_half,
    output logic         cfg_ready,
    output logic         busy,
    output logic         tick,
`ifdef CLKDIV_TICK_COUNT_EN
    output logic [15:0]  tick_cnt,
`endif
    output logic         clkOut
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STOPPING = 2'd2
    } state_t;

    state_t       state;
    logic [N-1:0] cnt;
    logic [N-1:0] half_act;
    logic [N-1:0] half_pend;
    logic         pend_v;

    logic boundary;
    logic eop;
    logic cfg_xfer;

    // A boundary ends a half period; the one that drops clkOut ends a whole period.
    assign boundary  = (cnt == half_act);
    assign eop       = boundary && clkOut;
    assign cfg_ready = (state == S_IDLE) || !pend_v;
    assign cfg_xfer  = cfg_valid && cfg_ready;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            clkOut    <= 1'b0;
            tick      <= 1'b0;
            half_act  <= N'(HALF_DEFAULT);
            half_pend <= '0;
            pend_v    <= 1'b0;
`ifdef CLKDIV_TICK_COUNT_EN
            tick_cnt  <= 16'd0;
`endif
        end else begin
            tick <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt    <= '0;
                    clkOut <= 1'b0;
                    if (cfg_xfer)
                        half_act <= cfg_half;
                    if (start)
                        state <= S_RUN;
                end
                default: begin
                    if (boundary) begin
                        cnt    <= '0;
                        clkOut <= ~clkOut;
                        tick   <= ~clkOut;
`ifdef CLKDIV_TICK_COUNT_EN
                        if (!clkOut)
                            tick_cnt <= tick_cnt + 16'd1;
`endif
                    end else begin
                        cnt <= cnt + N'(1);
                    end

                    // Pending H only takes effect between whole periods, so no
                    // half period is ever cut short. A transfer coinciding with
                    // the EOP (pend_v was 0) lands in half_pend for the next one.
                    if (eop && pend_v) begin
                        half_act <= half_pend;
                        pend_v   <= 1'b0;
                    end
                    if (cfg_xfer) begin
                        half_pend <= cfg_half;
                        pend_v    <= 1'b1;
                    end

                    if (state == S_RUN) begin
                        if (stop)
                            state <= S_STOPPING;
                    end else if (start) begin
                        // Cancelling a stop, even on the EOP itself, leaves the
                        // waveform untouched.
                        state <= S_RUN;
                    end else if (eop) begin
                        state <= S_IDLE;
                        // No further EOP will come to apply a same-cycle
                        // transfer, so take it straight into half_act.
                        if (cfg_xfer) begin
                            half_act <= cfg_half;
                            pend_v   <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_controller.sv
// tb/tb_clk_div_controller.sv - scoreboard bench for clk_div_controller

module tb_clk_div_controller;

    localparam int N = 26;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [N-1:0] cfg_half = '0;
    logic         cfg_ready;
    logic         busy;
    logic         tick;
    logic         clkOut;
`ifdef CLKDIV_TICK_COUNT_EN
    logic [15:0]  tick_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_q[$];
    logic prev_clk = 1'b0;

    clk_div_controller #(.N(N), .HALF_DEFAULT(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .cfg_valid (cfg_valid),
        .cfg_half  (cfg_half),
        .cfg_ready (cfg_ready),
        .busy      (busy),
        .tick      (tick),
`ifdef CLKDIV_TICK_COUNT_EN
        .tick_cnt  (tick_cnt),
`endif
        .clkOut    (clkOut)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Advance to #1 after edge number t.
    task automatic wait_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every tick pops its expected edge number from the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && tick) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_tick at cycle %0d: got tick expected none", cyc);
                end else begin
                    check("tick_time", cyc, exp_q.pop_front());
                    check("tick_clk_high", int'(clkOut), 1);
                    check("tick_clk_was_low", int'(prev_clk), 0);
                end
            end
            prev_clk = clkOut;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held across edges 1..3.
        wait_to(3);
        check("rst_cfg_ready", int'(cfg_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_clkout", int'(clkOut), 0);
        reset = 1'b0;

        // H=3 default: start sampled at edge 6, ticks every 8 from edge 10.
        wait_to(5);  start = 1'b1;
        wait_to(6);  start = 1'b0;
        exp_q.push_back(10); exp_q.push_back(18); exp_q.push_back(26);
        check("a_busy", int'(busy), 1);
        wait_to(9);  check("a_clk_9", int'(clkOut), 0);
        wait_to(10); check("a_clk_10", int'(clkOut), 1);
        wait_to(13); check("a_clk_13", int'(clkOut), 1);
        wait_to(14); check("a_clk_14", int'(clkOut), 0);
        // Stop one cycle after the tick at 26; EOP at 30.
        wait_to(26); stop = 1'b1;
        wait_to(27); stop = 1'b0;
        check("a_stopping_busy", int'(busy), 1);
        wait_to(29);
        check("a_busy_29", int'(busy), 1);
        check("a_clk_29", int'(clkOut), 1);
        wait_to(30);
        check("a_idle_busy", int'(busy), 0);
        check("a_idle_clk", int'(clkOut), 0);

        // H=0 in IDLE, start at 33: ticks every 2 cycles.
        wait_to(31); cfg_valid = 1'b1; cfg_half = 26'd0;
        check("b_cfg_ready_idle", int'(cfg_ready), 1);
        wait_to(32); cfg_valid = 1'b0; start = 1'b1;
        wait_to(33); start = 1'b0;
        exp_q.push_back(34); exp_q.push_back(36); exp_q.push_back(38); exp_q.push_back(40);
        wait_to(34); check("b_clk_34", int'(clkOut), 1);
        wait_to(35); check("b_clk_35", int'(clkOut), 0);
        wait_to(38); stop = 1'b1;
        wait_to(39); stop = 1'b0;
        wait_to(40);
        check("b_busy_40", int'(busy), 1);
        check("b_clk_40", int'(clkOut), 1);
        wait_to(41);
        check("b_idle_busy", int'(busy), 0);
        check("b_idle_clk", int'(clkOut), 0);

        // Back to H=3, start at 45; H=9 offered at edge 50 in the high phase.
        wait_to(42); cfg_valid = 1'b1; cfg_half = 26'd3;
        wait_to(43); cfg_valid = 1'b0;
        wait_to(44); start = 1'b1;
        wait_to(45); start = 1'b0;
        exp_q.push_back(49); exp_q.push_back(63); exp_q.push_back(83); exp_q.push_back(103);
        wait_to(49);
        check("c_cfg_ready_pre", int'(cfg_ready), 1);
        cfg_valid = 1'b1; cfg_half = 26'd9;
        wait_to(50); cfg_valid = 1'b0;
        check("c_cfg_ready_pend", int'(cfg_ready), 0);
        wait_to(52); check("c_cfg_ready_52", int'(cfg_ready), 0);
        wait_to(53);
        check("c_cfg_ready_eop", int'(cfg_ready), 1);
        check("c_clk_53", int'(clkOut), 0);
        wait_to(62); check("c_clk_62", int'(clkOut), 0);
        wait_to(63); check("c_clk_63", int'(clkOut), 1);
        wait_to(72); check("c_clk_72", int'(clkOut), 1);
        wait_to(73); check("c_clk_73", int'(clkOut), 0);

        // Stop at 74, then start exactly on the EOP at 93: keeps running.
        stop = 1'b1;
        wait_to(74); stop = 1'b0;
        wait_to(92); start = 1'b1;
        check("d_busy_92", int'(busy), 1);
        wait_to(93); start = 1'b0;
        check("d_busy_93", int'(busy), 1);
        check("d_clk_93", int'(clkOut), 0);
        wait_to(94); check("d_busy_94", int'(busy), 1);
        wait_to(103); check("d_clk_103", int'(clkOut), 1);

        // H=5 pending, then reset at edge 107 discards it.
        wait_to(104); cfg_valid = 1'b1; cfg_half = 26'd5;
        wait_to(105); cfg_valid = 1'b0;
        check("e_cfg_ready_pend", int'(cfg_ready), 0);
        wait_to(106); reset = 1'b1;
        wait_to(107);
        check("e_rst_cfg_ready", int'(cfg_ready), 1);
        check("e_rst_busy", int'(busy), 0);
        check("e_rst_tick", int'(tick), 0);
        check("e_rst_clkout", int'(clkOut), 0);
`ifdef CLKDIV_TICK_COUNT_EN
        check("e_rst_tick_cnt", int'(tick_cnt), 0);
`endif
        reset = 1'b0;
        wait_to(109); start = 1'b1;
        wait_to(110); start = 1'b0;
        exp_q.push_back(114); exp_q.push_back(122); exp_q.push_back(130);
        wait_to(117); check("e_clk_117", int'(clkOut), 1);
        wait_to(118); check("e_clk_118", int'(clkOut), 0);
        wait_to(122); check("e_clk_122", int'(clkOut), 1);
        wait_to(130); stop = 1'b1;
        wait_to(131); stop = 1'b0;
`ifdef CLKDIV_TICK_COUNT_EN
        check("e_tick_cnt_3", int'(tick_cnt), 3);
`endif
        wait_to(134);
        check("e_idle_busy", int'(busy), 0);
        check("e_idle_clk", int'(clkOut), 0);

        wait_to(150);
        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
